pacman_btn_conditioner: RTL and testbench

// - Front-end input stage for TopModule_GameLogic, sitting between the board push-buttons and the game logic.
// - Synchronises the four raw buttons, debounces each one and drives clean levels to the game logic's rbtn/lbtn/ubtn/dbtn inputs.
// - Also latches the most recent newly pressed button as a one-hot direction request, held until acknowledged by dir_ack.

---
 rtl/pacman_btn_conditioner.sv | 198 +++++++++++++++++++
 tb/tb_pacman_btn_conditioner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pacman_btn_conditioner.sv
// Input conditioner between the board push-buttons and the game logic.
// Synchronises and debounces the four raw buttons. Each newly pressed button
// is latched as a one-hot direction request that stays valid until the game
// logic acknowledges it.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   rbtn_raw       raw right button (asynchronous, may bounce)
//   lbtn_raw       raw left button
//   ubtn_raw       raw up button
//   dbtn_raw       raw down button
//   dir_ack        1-cycle pulse: game logic consumed dir_req
//   rbtn           debounced right level
//   lbtn           debounced left level
//   ubtn           debounced up level
//   dbtn           debounced down level
//   dir_req        one-hot direction: 0001 right, 0010 left, 0100 up, 1000 down
//   dir_req_valid  dir_req holds an unconsumed request
module pacman_btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rbtn_raw,
  input  logic       lbtn_raw,
  input  logic       ubtn_raw,
  input  logic       dbtn_raw,
  input  logic       dir_ack,
  output logic       rbtn,
  output logic       lbtn,
  output logic       ubtn,
  output logic       dbtn,
  output logic [3:0] dir_req,
  output logic       dir_req_valid
);

  localparam int unsigned NBTN = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_e;

  // Bit order everywhere: {down, up, left, right}
  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;
  logic [NBTN-1:0] level;
  logic [NBTN-1:0] level_dly_q;
  logic [NBTN-1:0] press_evt_c;

  assign raw = {dbtn_raw, ubtn_raw, lbtn_raw, rbtn_raw};

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce FSM
  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    db_state_e        state_q;
    db_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      unique case (state_q)
        RELEASED: begin
          if (sync2_q[i]) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            level_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!sync2_q[i]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q[i]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = RELEASED;
            level_d = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign level[i] = level_q;
  end

  assign rbtn = level[0];
  assign lbtn = level[1];
  assign ubtn = level[2];
  assign dbtn = level[3];

  // Delayed copy of the levels; a rising level is a press event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_dly_q <= '0;
    end else begin
      level_dly_q <= level;
    end
  end

  assign press_evt_c = level & ~level_dly_q;

  // Direction request latch: a new press always wins over an ack
  logic [3:0] dir_req_q;
  logic [3:0] dir_req_d;
  logic       dir_valid_q;
  logic       dir_valid_d;

  always_comb begin
    dir_req_d   = dir_req_q;
    dir_valid_d = dir_valid_q;
    if (press_evt_c[0]) begin
      dir_req_d   = 4'b0001;
      dir_valid_d = 1'b1;
    end else if (press_evt_c[1]) begin
      dir_req_d   = 4'b0010;
      dir_valid_d = 1'b1;
    end else if (press_evt_c[2]) begin
      dir_req_d   = 4'b0100;
      dir_valid_d = 1'b1;
    end else if (press_evt_c[3]) begin
      dir_req_d   = 4'b1000;
      dir_valid_d = 1'b1;
    end else if (dir_ack) begin
      dir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_req_q   <= 4'b0001;
      dir_valid_q <= 1'b0;
    end else begin
      dir_req_q   <= dir_req_d;
      dir_valid_q <= dir_valid_d;
    end
  end

  assign dir_req       = dir_req_q;
  assign dir_req_valid = dir_valid_q;

endmodule

// File: tb/tb_pacman_btn_conditioner.sv
// Directed bench for pacman_btn_conditioner with DEBOUNCE_CYCLES=4.
// Each table row drives the buttons and ack for 'reps' cycles. After every
// edge it checks the debounced levels, dir_req and dir_req_valid.
module tb_pacman_btn_conditioner;

  logic       clk;
  logic       rst;
  logic       rbtn_raw;
  logic       lbtn_raw;
  logic       ubtn_raw;
  logic       dbtn_raw;
  logic       dir_ack;
  logic       rbtn;
  logic       lbtn;
  logic       ubtn;
  logic       dbtn;
  logic [3:0] dir_req;
  logic       dir_req_valid;

  int total = 0;
  int bad   = 0;

  pacman_btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rbtn_raw     (rbtn_raw),
    .lbtn_raw     (lbtn_raw),
    .ubtn_raw     (ubtn_raw),
    .dbtn_raw     (dbtn_raw),
    .dir_ack      (dir_ack),
    .rbtn         (rbtn),
    .lbtn         (lbtn),
    .ubtn         (ubtn),
    .dbtn         (dbtn),
    .dir_req      (dir_req),
    .dir_req_valid(dir_req_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // btn and lv are {down, up, left, right}
  typedef struct {
    logic [3:0] btn;
    logic       ack;
    int         reps;
    logic [3:0] lv;
    logic [3:0] dir;
    logic       v;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] btn, input logic ack, input int reps,
                              input logic [3:0] lv, input logic [3:0] dir, input logic v);
    vec_t r;
    r.btn  = btn;
    r.ack  = ack;
    r.reps = reps;
    r.lv   = lv;
    r.dir  = dir;
    r.v    = v;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] btn, input logic ack);
    rbtn_raw = btn[0];
    lbtn_raw = btn[1];
    ubtn_raw = btn[2];
    dbtn_raw = btn[3];
    dir_ack  = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] lv, input logic [3:0] dir,
                         input logic v);
    chk({nm, " lv"}, {dbtn, ubtn, lbtn, rbtn}, lv);
    chk({nm, " dir"}, dir_req, dir);
    chk({nm, " valid"}, {3'b000, dir_req_valid}, {3'b000, v});
  endtask

  initial begin
    // Idle after reset
    add(4'b0000, 1'b0, 5, 4'b0000, 4'b0001, 1'b0);
    // Right held: level at 6th edge, request at 7th, single event over a long hold
    add(4'b0001, 1'b0, 5, 4'b0000, 4'b0001, 1'b0);
    add(4'b0001, 1'b0, 1, 4'b0001, 4'b0001, 1'b0);
    add(4'b0001, 1'b0, 50, 4'b0001, 4'b0001, 1'b1);
    // Ack alone clears valid and keeps the heading
    add(4'b0001, 1'b1, 1, 4'b0001, 4'b0001, 1'b0);
    add(4'b0001, 1'b0, 3, 4'b0001, 4'b0001, 1'b0);
    // Release right: no event
    add(4'b0000, 1'b0, 5, 4'b0001, 4'b0001, 1'b0);
    add(4'b0000, 1'b0, 2, 4'b0000, 4'b0001, 1'b0);
    // Up bounces 1,1,0,1,0 then holds
    add(4'b0100, 1'b0, 2, 4'b0000, 4'b0001, 1'b0);
    add(4'b0000, 1'b0, 1, 4'b0000, 4'b0001, 1'b0);
    add(4'b0100, 1'b0, 1, 4'b0000, 4'b0001, 1'b0);
    add(4'b0000, 1'b0, 1, 4'b0000, 4'b0001, 1'b0);
    add(4'b0100, 1'b0, 5, 4'b0000, 4'b0001, 1'b0);
    add(4'b0100, 1'b0, 1, 4'b0100, 4'b0001, 1'b0);
    add(4'b0100, 1'b0, 3, 4'b0100, 4'b0100, 1'b1);
    // Left and down together: left wins, overwrites unacked up
    add(4'b1110, 1'b0, 5, 4'b0100, 4'b0100, 1'b1);
    add(4'b1110, 1'b0, 1, 4'b1110, 4'b0100, 1'b1);
    add(4'b1110, 1'b0, 3, 4'b1110, 4'b0010, 1'b1);
    // Release down: no event
    add(4'b0110, 1'b0, 5, 4'b1110, 4'b0010, 1'b1);
    add(4'b0110, 1'b0, 1, 4'b0110, 4'b0010, 1'b1);
    // Re-press down with ack landing on the event cycle: event wins
    add(4'b1110, 1'b0, 5, 4'b0110, 4'b0010, 1'b1);
    add(4'b1110, 1'b0, 1, 4'b1110, 4'b0010, 1'b1);
    add(4'b1110, 1'b1, 1, 4'b1110, 4'b1000, 1'b1);
    add(4'b1110, 1'b0, 3, 4'b1110, 4'b1000, 1'b1);
    // Ack clears, second ack with valid=0 is ignored
    add(4'b1110, 1'b1, 1, 4'b1110, 4'b1000, 1'b0);
    add(4'b1110, 1'b1, 1, 4'b1110, 4'b1000, 1'b0);
    add(4'b1110, 1'b0, 2, 4'b1110, 4'b1000, 1'b0);
    // Release all
    add(4'b0000, 1'b0, 5, 4'b1110, 4'b1000, 1'b0);
    add(4'b0000, 1'b0, 3, 4'b0000, 4'b1000, 1'b0);
    // Up pressed and held, giving a pending request before the reset test
    add(4'b0100, 1'b0, 5, 4'b0000, 4'b1000, 1'b0);
    add(4'b0100, 1'b0, 1, 4'b0100, 4'b1000, 1'b0);
    add(4'b0100, 1'b0, 2, 4'b0100, 4'b0100, 1'b1);

    rst = 1'b0;
    drive(4'b0000, 1'b0);
    #28;
    chk_all("reset", 4'b0000, 4'b0001, 1'b0);
    #2;
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        drive(tbl[i].btn, tbl[i].ack);
        tick();
        chk_all($sformatf("vec%0d.%0d", i, k), tbl[i].lv, tbl[i].dir, tbl[i].v);
      end
    end

    // Reset mid-PRESS_WAIT of right, up held: short async pulse between edges
    drive(4'b0101, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #2;
    chk_all("rst_pulse", 4'b0000, 4'b0001, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk_all("rst_after", 4'b0000, 4'b0001, 1'b0);

    // Both held buttons requalify; right wins the simultaneous event
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all($sformatf("requal%0d", k), 4'b0000, 4'b0001, 1'b0);
    end
    tick();
    chk_all("requal6", 4'b0101, 4'b0001, 1'b0);
    tick();
    chk_all("requal_evt", 4'b0101, 4'b0001, 1'b1);
    repeat (20) tick();
    chk_all("requal_hold", 4'b0101, 4'b0001, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
